io_input_cond: RTL
==================

# io_input_cond

Input conditioner for the memory-mapped switch and button inputs read by the pipeline's load/store unit. It takes the raw, asynchronous board pins, synchronises and debounces every bit, and latches sticky press events for each button. It drives the `i_io_sw` and `i_io_btn` words consumed by the core, and takes a clear strobe from the LSU so software can acknowledge events.

## Interface

**Parameters**
- `NUM_SW`, default 18: number of switch pins, 1..32.
- `NUM_BTN`, default 4: number of button pins, 1..16.
- `BTN_ACTIVE_LOW`, default 1: button pins read 0 when pressed; they are inverted before synchronisation.
- `DB_LIMIT`, default 500000: consecutive differing cycles required to accept a change (10 ms at 50 MHz). Must be ≥1.
- `DB_CNT_W`, default 20: counter width. Must satisfy 2^DB_CNT_W ≥ DB_LIMIT.

**Ports**
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_sw_pin` in NUM_SW: raw switch pins, asynchronous.
- `i_btn_pin` in NUM_BTN: raw button pins, asynchronous.
- `i_evt_clr` in 1: one-cycle clear strobe from the LSU.
- `i_evt_clr_mask` in NUM_BTN: selects which events the strobe clears.
- `o_io_sw` out 32: debounced switch levels in bits [NUM_SW-1:0]; upper bits 0.
- `o_io_btn` out 32: debounced pressed levels in bits [NUM_BTN-1:0]; sticky press events in bits [16+NUM_BTN-1:16]; all other bits 0.

## Operation

**Pre-inversion.** When BTN_ACTIVE_LOW=1, each button pin is inverted before synchronisation. After this step, 1 means pressed for every button.

**Synchronisation.** Each bit passes through two flops, giving signal `y`.

**Debounce, per bit.** Each bit keeps a stable level `s` and a counter `c`.
- If y == s: c ← 0.
- If y != s and c == DB_LIMIT-1: s ← y and c ← 0.
- Otherwise: c ← c+1.
- Consequence: any return of y to s before the limit restarts the count, so glitches shorter than DB_LIMIT cycles never reach the output.

**Outputs.** `o_io_sw` and the level field of `o_io_btn` come directly from the `s` registers.

**Press events, per button.**
- Set: when `s` transitions 0→1, the event bit is set on the same edge that `s` updates.
- Clear: when i_evt_clr=1, event bits whose mask bit is 1 are cleared.
- Set and clear on the same edge: set wins, so no press is lost.
- A release (`s` going 1→0) does not affect the event bit.

## Timing

- **Reset.** All sync flops, `s`, `c` and event bits go to 0, so `o_io_sw` = 0 and `o_io_btn` = 0 on the edge after i_rst is sampled high.
  - Reset mid-count discards the partial count.
  - A pin held in the non-zero state through reset appears at the output DB_LIMIT+2 edges after reset deasserts.
- **Latency.** A pin that changes and then holds shows on the output DB_LIMIT+2 rising edges later: 2 for synchronisation, DB_LIMIT for the debounce.
- **Event timing.** The event bit becomes visible in the same cycle as the level bit.
- **Clear timing.** The clear takes effect on the edge at which i_evt_clr is sampled. i_evt_clr is not edge-detected: holding it high clears on every cycle.
- **DB_LIMIT = 1.** The block is pure synchronisation: latency 3 edges.
- **Counter range.** The counter never exceeds DB_LIMIT-1, so there is no wrap-around.

## Structure

- Package `io_pkg`:
  - `IO_BTN_EVT_LSB = 16`
  - `DB_LIMIT_DEFAULT`
  - `DB_CNT_W_DEFAULT`
  - typedef `io_word_t` (logic [31:0])
- Sub-module `debounce_bit`, instantiated once per switch and button via generate.
  - Contains the 2-flop synchroniser, `s`, `c`, and a one-cycle `o_rise` pulse.
  - Parameters: DB_LIMIT, DB_CNT_W.
- The top level holds the pre-inversion, the event registers with clear logic, and the 32-bit output packing.

## Test plan

All scenarios use DB_LIMIT=4, NUM_SW=18, NUM_BTN=4, BTN_ACTIVE_LOW=1.

1. **Reset.** Pins: sw=0x3FFFF, btn=0xF (all buttons released). Assert i_rst for 3 cycles. → `o_io_sw`=0 and `o_io_btn`=0 from the first post-reset edge. After release, `o_io_sw`=0x3FFFF exactly 6 edges later.
2. **Clean press.** Drive btn pin 2 low and hold. → `o_io_btn`=0x0004_0004 exactly 6 edges later. Then release: level bit clears 6 edges later, event bit stays, `o_io_btn`=0x0004_0000.
3. **Glitch rejection.** Pulse switch 5 high for 3 cycles, then low. → `o_io_sw` stays 0 throughout. A 4-cycle pulse → bit 5 goes high.
4. **Clear with mask.** Set events 0 and 3. Pulse i_evt_clr with mask 0x1. → `o_io_btn`[19:16]=0x8 on the next edge.
5. **Set/clear collision.** Time a press of button 1 so its `s` rises on the same edge that i_evt_clr with mask 0x2 is sampled. → event bit 17 = 1 after that edge.
6. **Mid-count reset.** Change switch 0, assert i_rst after 2 cycles, deassert. → the output holds 0 for 6 edges, then shows the pin level.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and types for the switch/button input conditioner.
package io_pkg;

    localparam int IO_BTN_EVT_LSB   = 16;
    localparam int DB_LIMIT_DEFAULT = 500000;
    localparam int DB_CNT_W_DEFAULT = 20;

    typedef logic [31:0] io_word_t;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser followed by a counting debouncer.
// o_rise is combinational and marks the edge on which the stable level goes 0->1.
module debounce_bit #(
    parameter int DB_LIMIT = 4,
    parameter int DB_CNT_W = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);
    localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                w_accept;

    // The candidate level has differed for DB_LIMIT consecutive edges.
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == LIMIT_M1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous
            // stage's old value, which is what makes this a real 2-flop chain.
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_accept && r_sync2;

endmodule

// File: rtl/io_input_cond.sv
// Switch/button input conditioner: synchronise and debounce every pin, latch
// sticky press events per button, and pack both into 32-bit LSU-readable words.
module io_input_cond
    import io_pkg::*;
#(
    parameter int NUM_SW         = 18,
    parameter int NUM_BTN        = 4,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int DB_LIMIT       = DB_LIMIT_DEFAULT,
    parameter int DB_CNT_W       = DB_CNT_W_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SW-1:0]  i_sw_pin,
    input  logic [NUM_BTN-1:0] i_btn_pin,
    input  logic               i_evt_clr,
    input  logic [NUM_BTN-1:0] i_evt_clr_mask,
    output logic [31:0]        o_io_sw,
    output logic [31:0]        o_io_btn
);

    logic [NUM_BTN-1:0] w_btn_cond;
    logic [NUM_SW-1:0]  w_sw_level;
    logic [NUM_SW-1:0]  w_sw_rise_unused;
    logic [NUM_BTN-1:0] w_btn_level;
    logic [NUM_BTN-1:0] w_btn_rise;
    logic [NUM_BTN-1:0] w_clr_mask;
    logic [NUM_BTN-1:0] r_evt;
    io_word_t           w_sw_word;
    io_word_t           w_btn_word;

    // After this, a 1 always means "pressed" regardless of board wiring.
    assign w_btn_cond = i_btn_pin ^ {NUM_BTN{BTN_ACTIVE_LOW != 0}};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_bit #(
            .DB_LIMIT (DB_LIMIT),
            .DB_CNT_W (DB_CNT_W)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_pin   (i_sw_pin[g]),
            .o_level (w_sw_level[g]),
            .o_rise  (w_sw_rise_unused[g])
        );
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_bit #(
            .DB_LIMIT (DB_LIMIT),
            .DB_CNT_W (DB_CNT_W)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_pin   (w_btn_cond[g]),
            .o_level (w_btn_level[g]),
            .o_rise  (w_btn_rise[g])
        );
    end

    assign w_clr_mask = i_evt_clr ? i_evt_clr_mask : '0;

    // Set is OR-ed in after the clear so a press coinciding with a clear is kept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~w_clr_mask) | w_btn_rise;
        end
    end

    always_comb begin
        // NOTE: defaulting every bit first keeps this block free of latches.
        w_sw_word  = '0;
        w_btn_word = '0;
        w_sw_word[NUM_SW-1:0]                   = w_sw_level;
        w_btn_word[NUM_BTN-1:0]                 = w_btn_level;
        w_btn_word[IO_BTN_EVT_LSB +: NUM_BTN]   = r_evt;
    end

    assign o_io_sw  = w_sw_word;
    assign o_io_btn = w_btn_word;

endmodule
